// File: rtl/axi_read_arbiter.sv
// axi_read_arbiter
//   Shares one AXI read port (AR + R) between the instruction cache (ic_*)
//   and the data cache (dc_*). Round-robin grant, held from AR issue until
//   the R beat carrying rlast completes. Read data is routed only to the owner.
// Ports:
//   clock, reset                 single clock, synchronous active-high reset
//   ic_* / dc_* AR inputs        requester address channel (valid/addr/len/size/burst)
//   ic_arready / dc_arready      memory AR accept, forwarded to the owner only
//   ic_r* / dc_r* outputs        routed R channel (owner only, zero otherwise)
//   ic_rready / dc_rready        requester R ready
//   m_axi_*                      AXI read master port towards memory
//   icache_busy / dcache_busy    requester currently owns the port
//   len_error                    sticky: beat count at rlast != latched arlen+1
module axi_read_arbiter #(
    parameter int unsigned ADDR_WIDTH = 64,
    parameter int unsigned DATA_WIDTH = 64
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  ic_arvalid,
    input  logic [ADDR_WIDTH-1:0] ic_araddr,
    input  logic [7:0]            ic_arlen,
    input  logic [2:0]            ic_arsize,
    input  logic [1:0]            ic_arburst,
    output logic                  ic_arready,
    output logic                  ic_rvalid,
    output logic [DATA_WIDTH-1:0] ic_rdata,
    output logic                  ic_rlast,
    input  logic                  ic_rready,
    input  logic                  dc_arvalid,
    input  logic [ADDR_WIDTH-1:0] dc_araddr,
    input  logic [7:0]            dc_arlen,
    input  logic [2:0]            dc_arsize,
    input  logic [1:0]            dc_arburst,
    output logic                  dc_arready,
    output logic                  dc_rvalid,
    output logic [DATA_WIDTH-1:0] dc_rdata,
    output logic                  dc_rlast,
    input  logic                  dc_rready,
    output logic                  m_axi_arvalid,
    output logic [ADDR_WIDTH-1:0] m_axi_araddr,
    output logic [7:0]            m_axi_arlen,
    output logic [2:0]            m_axi_arsize,
    output logic [1:0]            m_axi_arburst,
    input  logic                  m_axi_arready,
    input  logic                  m_axi_rvalid,
    input  logic [DATA_WIDTH-1:0] m_axi_rdata,
    input  logic                  m_axi_rlast,
    output logic                  m_axi_rready,
    output logic                  icache_busy,
    output logic                  dcache_busy,
    output logic                  len_error
);

    typedef enum logic [1:0] {ST_IDLE, ST_ADDR, ST_DATA} state_t;
    typedef enum logic [1:0] {OWN_NONE, OWN_IC, OWN_DC} owner_t;

    state_t                state_q, state_d;
    owner_t                owner_q, owner_d;
    owner_t                last_grant_q, last_grant_d;
    logic [ADDR_WIDTH-1:0] araddr_q, araddr_d;
    logic [7:0]            arlen_q, arlen_d;
    logic [2:0]            arsize_q, arsize_d;
    logic [1:0]            arburst_q, arburst_d;
    logic                  arvalid_q, arvalid_d;
    logic [8:0]            beat_cnt_q, beat_cnt_d;
    logic                  len_error_q, len_error_d;

    logic is_ic;
    logic is_dc;

    assign is_ic = (owner_q == OWN_IC);
    assign is_dc = (owner_q == OWN_DC);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            owner_q      <= OWN_NONE;
            last_grant_q <= OWN_IC;
            araddr_q     <= '0;
            arlen_q      <= '0;
            arsize_q     <= '0;
            arburst_q    <= '0;
            arvalid_q    <= 1'b0;
            beat_cnt_q   <= '0;
            len_error_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            araddr_q     <= araddr_d;
            arlen_q      <= arlen_d;
            arsize_q     <= arsize_d;
            arburst_q    <= arburst_d;
            arvalid_q    <= arvalid_d;
            beat_cnt_q   <= beat_cnt_d;
            len_error_q  <= len_error_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        araddr_d     = araddr_q;
        arlen_d      = arlen_q;
        arsize_d     = arsize_q;
        arburst_d    = arburst_q;
        arvalid_d    = 1'b0;
        beat_cnt_d   = beat_cnt_q;
        len_error_d  = len_error_q;

        case (state_q)
            ST_IDLE: begin
                // On a tie the requester that did not win last time is granted.
                if (ic_arvalid && (!dc_arvalid || last_grant_q == OWN_DC)) begin
                    owner_d      = OWN_IC;
                    last_grant_d = OWN_IC;
                    araddr_d     = ic_araddr;
                    arlen_d      = ic_arlen;
                    arsize_d     = ic_arsize;
                    arburst_d    = ic_arburst;
                    state_d      = ST_ADDR;
                end else if (dc_arvalid) begin
                    owner_d      = OWN_DC;
                    last_grant_d = OWN_DC;
                    araddr_d     = dc_araddr;
                    arlen_d      = dc_arlen;
                    arsize_d     = dc_arsize;
                    arburst_d    = dc_arburst;
                    state_d      = ST_ADDR;
                end
            end
            ST_ADDR: begin
                // arvalid_q rises one cycle into ADDR and holds until accepted.
                if (arvalid_q && m_axi_arready) begin
                    state_d    = ST_DATA;
                    beat_cnt_d = '0;
                end else begin
                    arvalid_d = 1'b1;
                end
            end
            ST_DATA: begin
                if (m_axi_rvalid && m_axi_rready) begin
                    beat_cnt_d = beat_cnt_q + 9'd1;
                    if (m_axi_rlast) begin
                        // beat_cnt_q+1 != arlen+1 reduces to beat_cnt_q != arlen
                        if (beat_cnt_q != {1'b0, arlen_q}) begin
                            len_error_d = 1'b1;
                        end
                        state_d = ST_IDLE;
                        owner_d = OWN_NONE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                owner_d = OWN_NONE;
            end
        endcase
    end

    // Output routing
    always_comb begin
        m_axi_arvalid = arvalid_q;
        m_axi_araddr  = araddr_q;
        m_axi_arlen   = arlen_q;
        m_axi_arsize  = arsize_q;
        m_axi_arburst = arburst_q;
        m_axi_rready  = 1'b0;
        ic_arready    = 1'b0;
        dc_arready    = 1'b0;
        ic_rvalid     = 1'b0;
        ic_rdata      = '0;
        ic_rlast      = 1'b0;
        dc_rvalid     = 1'b0;
        dc_rdata      = '0;
        dc_rlast      = 1'b0;
        icache_busy   = is_ic;
        dcache_busy   = is_dc;
        len_error     = len_error_q;

        if (state_q == ST_ADDR) begin
            ic_arready = is_ic && arvalid_q && m_axi_arready;
            dc_arready = is_dc && arvalid_q && m_axi_arready;
        end

        if (state_q == ST_DATA) begin
            m_axi_rready = (is_ic && ic_rready) || (is_dc && dc_rready);
            if (is_ic) begin
                ic_rvalid = m_axi_rvalid;
                ic_rdata  = m_axi_rdata;
                ic_rlast  = m_axi_rlast;
            end
            if (is_dc) begin
                dc_rvalid = m_axi_rvalid;
                dc_rdata  = m_axi_rdata;
                dc_rlast  = m_axi_rlast;
            end
        end
    end

endmodule

// File: tb/tb_axi_read_arbiter.sv
module tb_axi_read_arbiter;

    logic        clock;
    logic        reset;
    logic        ic_arvalid, dc_arvalid;
    logic [63:0] ic_araddr, dc_araddr;
    logic [7:0]  ic_arlen, dc_arlen;
    logic [2:0]  ic_arsize, dc_arsize;
    logic [1:0]  ic_arburst, dc_arburst;
    logic        ic_arready, dc_arready;
    logic        ic_rvalid, dc_rvalid;
    logic [63:0] ic_rdata, dc_rdata;
    logic        ic_rlast, dc_rlast;
    logic        ic_rready, dc_rready;
    logic        m_axi_arvalid;
    logic [63:0] m_axi_araddr;
    logic [7:0]  m_axi_arlen;
    logic [2:0]  m_axi_arsize;
    logic [1:0]  m_axi_arburst;
    logic        m_axi_arready;
    logic        m_axi_rvalid;
    logic [63:0] m_axi_rdata;
    logic        m_axi_rlast;
    logic        m_axi_rready;
    logic        icache_busy, dcache_busy, len_error;

    int compared;
    int mismatched;

    axi_read_arbiter #(.ADDR_WIDTH(64), .DATA_WIDTH(64)) dut (
        .clock(clock), .reset(reset),
        .ic_arvalid(ic_arvalid), .ic_araddr(ic_araddr), .ic_arlen(ic_arlen),
        .ic_arsize(ic_arsize), .ic_arburst(ic_arburst), .ic_arready(ic_arready),
        .ic_rvalid(ic_rvalid), .ic_rdata(ic_rdata), .ic_rlast(ic_rlast), .ic_rready(ic_rready),
        .dc_arvalid(dc_arvalid), .dc_araddr(dc_araddr), .dc_arlen(dc_arlen),
        .dc_arsize(dc_arsize), .dc_arburst(dc_arburst), .dc_arready(dc_arready),
        .dc_rvalid(dc_rvalid), .dc_rdata(dc_rdata), .dc_rlast(dc_rlast), .dc_rready(dc_rready),
        .m_axi_arvalid(m_axi_arvalid), .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
        .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst), .m_axi_arready(m_axi_arready),
        .m_axi_rvalid(m_axi_rvalid), .m_axi_rdata(m_axi_rdata), .m_axi_rlast(m_axi_rlast),
        .m_axi_rready(m_axi_rready),
        .icache_busy(icache_busy), .dcache_busy(dcache_busy), .len_error(len_error)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Memory-side stimulus only: n beats with data base+i, rlast on the final beat if requested.
    task automatic serve_beats(input int n, input logic [63:0] base, input bit with_last);
        for (int i = 0; i < n; i++) begin
            m_axi_rvalid = 1'b1;
            m_axi_rdata  = base + 64'(i);
            m_axi_rlast  = with_last && (i == n - 1);
            tick();
        end
        m_axi_rvalid = 1'b0;
        m_axi_rlast  = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        compared++; if (m_axi_arvalid !== 1'b0) begin mismatched++; $display("FAIL rst_arvalid: got %b exp 0", m_axi_arvalid); end
        compared++; if (m_axi_rready !== 1'b0) begin mismatched++; $display("FAIL rst_rready: got %b exp 0", m_axi_rready); end
        compared++; if ({icache_busy, dcache_busy} !== 2'b00) begin mismatched++; $display("FAIL rst_busy: got %b exp 00", {icache_busy, dcache_busy}); end
        compared++; if (len_error !== 1'b0) begin mismatched++; $display("FAIL rst_len_error: got %b exp 0", len_error); end
        compared++; if (m_axi_araddr !== 64'h0) begin mismatched++; $display("FAIL rst_araddr: got %h exp 0", m_axi_araddr); end
        reset = 1'b0;
    endtask

    task automatic test_tie();
        ic_araddr = 64'h2000; ic_arlen = 8'd1;
        dc_araddr = 64'h3000; dc_arlen = 8'd1;
        ic_arvalid = 1'b1; dc_arvalid = 1'b1;
        tick();
        compared++; if ({icache_busy, dcache_busy} !== 2'b01) begin mismatched++; $display("FAIL tie1_grant: got ic/dc busy %b exp 01", {icache_busy, dcache_busy}); end
        tick();
        compared++; if (m_axi_araddr !== 64'h3000) begin mismatched++; $display("FAIL tie1_araddr: got %h exp 3000", m_axi_araddr); end
        compared++; if ({ic_arready, dc_arready} !== 2'b01) begin mismatched++; $display("FAIL tie1_arready: got ic/dc %b exp 01", {ic_arready, dc_arready}); end
        tick();
        dc_arvalid = 1'b0;
        m_axi_rvalid = 1'b1; m_axi_rdata = 64'hC0; m_axi_rlast = 1'b0;
        #1;
        compared++; if (dc_rdata !== 64'hC0) begin mismatched++; $display("FAIL tie1_dc_rdata: got %h exp c0", dc_rdata); end
        compared++; if ({ic_rvalid, dc_rvalid} !== 2'b01) begin mismatched++; $display("FAIL tie1_rvalid: got ic/dc %b exp 01", {ic_rvalid, dc_rvalid}); end
        compared++; if (ic_rdata !== 64'h0) begin mismatched++; $display("FAIL tie1_ic_rdata_gated: got %h exp 0", ic_rdata); end
        tick();
        m_axi_rdata = 64'hC1; m_axi_rlast = 1'b1;
        #1;
        compared++; if ({ic_rlast, dc_rlast} !== 2'b01) begin mismatched++; $display("FAIL tie1_rlast: got ic/dc %b exp 01", {ic_rlast, dc_rlast}); end
        tick();
        m_axi_rvalid = 1'b0; m_axi_rlast = 1'b0;
        // IDLE turnaround with IC still pending
        compared++; if ({icache_busy, dcache_busy, m_axi_arvalid} !== 3'b000) begin mismatched++; $display("FAIL tie1_turnaround: got busy/arvalid %b exp 000", {icache_busy, dcache_busy, m_axi_arvalid}); end
        tick();
        compared++; if ({icache_busy, dcache_busy} !== 2'b10) begin mismatched++; $display("FAIL tie1_ic_next: got ic/dc busy %b exp 10", {icache_busy, dcache_busy}); end
        tick();
        compared++; if (m_axi_araddr !== 64'h2000) begin mismatched++; $display("FAIL tie1_ic_araddr: got %h exp 2000", m_axi_araddr); end
        tick();
        ic_arvalid = 1'b0;
        serve_beats(2, 64'hC100, 1'b1);
        // DC-only burst so that the next tie must go to IC
        dc_araddr = 64'h4000; dc_arlen = 8'd0; dc_arvalid = 1'b1;
        tick(); tick(); tick();
        dc_arvalid = 1'b0;
        serve_beats(1, 64'hC200, 1'b1);
        ic_araddr = 64'h2100; ic_arlen = 8'd0;
        dc_araddr = 64'h3100; dc_arlen = 8'd0;
        ic_arvalid = 1'b1; dc_arvalid = 1'b1;
        tick();
        compared++; if ({icache_busy, dcache_busy} !== 2'b10) begin mismatched++; $display("FAIL tie2_grant: got ic/dc busy %b exp 10", {icache_busy, dcache_busy}); end
        tick();
        compared++; if (m_axi_araddr !== 64'h2100) begin mismatched++; $display("FAIL tie2_araddr: got %h exp 2100", m_axi_araddr); end
        tick();
        ic_arvalid = 1'b0;
        serve_beats(1, 64'hC300, 1'b1);
        tick();
        compared++; if ({icache_busy, dcache_busy} !== 2'b01) begin mismatched++; $display("FAIL tie2_dc_next: got ic/dc busy %b exp 01", {icache_busy, dcache_busy}); end
        tick();
        compared++; if (m_axi_araddr !== 64'h3100) begin mismatched++; $display("FAIL tie2_dc_araddr: got %h exp 3100", m_axi_araddr); end
        tick();
        dc_arvalid = 1'b0;
        serve_beats(1, 64'hC400, 1'b1);
    endtask

    task automatic test_ic_only();
        ic_araddr = 64'h1000; ic_arlen = 8'd7; ic_arsize = 3'd3; ic_arburst = 2'd1;
        ic_arvalid = 1'b1;
        tick();
        compared++; if (m_axi_arvalid !== 1'b0) begin mismatched++; $display("FAIL ic_lat1_arvalid: got %b exp 0", m_axi_arvalid); end
        compared++; if (icache_busy !== 1'b1) begin mismatched++; $display("FAIL ic_busy_grant: got %b exp 1", icache_busy); end
        tick();
        compared++; if (m_axi_arvalid !== 1'b1) begin mismatched++; $display("FAIL ic_lat2_arvalid: got %b exp 1", m_axi_arvalid); end
        compared++; if (m_axi_araddr !== 64'h1000) begin mismatched++; $display("FAIL ic_araddr: got %h exp 1000", m_axi_araddr); end
        compared++; if ({m_axi_arlen, m_axi_arsize, m_axi_arburst} !== {8'd7, 3'd3, 2'd1}) begin mismatched++; $display("FAIL ic_arfields: got %h/%h/%h exp 7/3/1", m_axi_arlen, m_axi_arsize, m_axi_arburst); end
        compared++; if ({ic_arready, dc_arready} !== 2'b10) begin mismatched++; $display("FAIL ic_arready: got ic/dc %b exp 10", {ic_arready, dc_arready}); end
        tick();
        ic_arvalid = 1'b0;
        compared++; if (m_axi_arvalid !== 1'b0) begin mismatched++; $display("FAIL ic_arvalid_drop: got %b exp 0", m_axi_arvalid); end
        for (int i = 0; i < 8; i++) begin
            m_axi_rvalid = 1'b1; m_axi_rdata = 64'hA000 + 64'(i); m_axi_rlast = (i == 7);
            #1;
            compared++; if ({ic_rvalid, dc_rvalid, m_axi_rready} !== 3'b101) begin mismatched++; $display("FAIL ic_beat%0d_valid: got ic/dc/rready %b exp 101", i, {ic_rvalid, dc_rvalid, m_axi_rready}); end
            compared++; if (ic_rdata !== 64'hA000 + 64'(i)) begin mismatched++; $display("FAIL ic_beat%0d_rdata: got %h exp %h", i, ic_rdata, 64'hA000 + 64'(i)); end
            compared++; if (ic_rlast !== (i == 7)) begin mismatched++; $display("FAIL ic_beat%0d_rlast: got %b exp %b", i, ic_rlast, (i == 7)); end
            tick();
        end
        m_axi_rvalid = 1'b0; m_axi_rlast = 1'b0;
        compared++; if ({icache_busy, len_error} !== 2'b00) begin mismatched++; $display("FAIL ic_end: got busy/len_error %b exp 00", {icache_busy, len_error}); end
    endtask

    task automatic test_backpressure();
        int k;
        m_axi_arready = 1'b0;
        ic_araddr = 64'h5000; ic_arlen = 8'd7; ic_arvalid = 1'b1;
        tick();
        ic_araddr = 64'hFFFF;
        tick();
        for (int c = 0; c < 5; c++) begin
            compared++; if ({m_axi_arvalid, ic_arready} !== 2'b10) begin mismatched++; $display("FAIL bp_hold%0d: got arvalid/arready %b exp 10", c, {m_axi_arvalid, ic_arready}); end
            compared++; if (m_axi_araddr !== 64'h5000) begin mismatched++; $display("FAIL bp_addr%0d: got %h exp 5000", c, m_axi_araddr); end
            tick();
        end
        m_axi_arready = 1'b1;
        #1;
        compared++; if (ic_arready !== 1'b1) begin mismatched++; $display("FAIL bp_arready: got %b exp 1", ic_arready); end
        tick();
        ic_arvalid = 1'b0;
        k = 0;
        for (int c = 0; c < 40 && k < 8; c++) begin
            ic_rready = (c % 2 == 1);
            m_axi_rvalid = 1'b1; m_axi_rdata = 64'hB000 + 64'(k); m_axi_rlast = (k == 7);
            #1;
            compared++; if (m_axi_rready !== ic_rready) begin mismatched++; $display("FAIL bp_rready%0d: got %b exp %b", c, m_axi_rready, ic_rready); end
            if (ic_rready) begin
                compared++; if (ic_rdata !== 64'hB000 + 64'(k)) begin mismatched++; $display("FAIL bp_rdata%0d: got %h exp %h", k, ic_rdata, 64'hB000 + 64'(k)); end
                k++;
            end
            tick();
        end
        m_axi_rvalid = 1'b0; m_axi_rlast = 1'b0; ic_rready = 1'b1;
        compared++; if (k !== 8) begin mismatched++; $display("FAIL bp_beats: got %0d exp 8", k); end
        compared++; if ({icache_busy, len_error} !== 2'b00) begin mismatched++; $display("FAIL bp_end: got busy/len_error %b exp 00", {icache_busy, len_error}); end
    endtask

    task automatic test_len_error();
        ic_araddr = 64'h6000; ic_arlen = 8'd7; ic_arvalid = 1'b1;
        tick(); tick(); tick();
        ic_arvalid = 1'b0;
        serve_beats(4, 64'hD000, 1'b1);
        compared++; if ({len_error, icache_busy} !== 2'b10) begin mismatched++; $display("FAIL len_set: got len_error/busy %b exp 10", {len_error, icache_busy}); end
        dc_araddr = 64'h6100; dc_arlen = 8'd1; dc_arvalid = 1'b1;
        tick(); tick(); tick();
        dc_arvalid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            m_axi_rvalid = 1'b1; m_axi_rdata = 64'hD100 + 64'(i); m_axi_rlast = (i == 1);
            #1;
            compared++; if (dc_rdata !== 64'hD100 + 64'(i)) begin mismatched++; $display("FAIL len_next_rdata%0d: got %h exp %h", i, dc_rdata, 64'hD100 + 64'(i)); end
            tick();
        end
        m_axi_rvalid = 1'b0; m_axi_rlast = 1'b0;
        tick();
        compared++; if ({len_error, dcache_busy} !== 2'b10) begin mismatched++; $display("FAIL len_sticky: got len_error/busy %b exp 10", {len_error, dcache_busy}); end
    endtask

    task automatic test_reset_mid_burst();
        ic_araddr = 64'h7000; ic_arlen = 8'd7; ic_arvalid = 1'b1;
        tick(); tick(); tick();
        ic_arvalid = 1'b0;
        serve_beats(3, 64'hE000, 1'b0);
        m_axi_rvalid = 1'b1; m_axi_rdata = 64'hE003;
        reset = 1'b1;
        tick();
        compared++; if ({m_axi_rready, ic_rvalid, m_axi_arvalid} !== 3'b000) begin mismatched++; $display("FAIL mid_rst_outs: got rready/ic_rvalid/arvalid %b exp 000", {m_axi_rready, ic_rvalid, m_axi_arvalid}); end
        compared++; if ({icache_busy, dcache_busy, len_error} !== 3'b000) begin mismatched++; $display("FAIL mid_rst_flags: got busy/busy/len_error %b exp 000", {icache_busy, dcache_busy, len_error}); end
        compared++; if (ic_rdata !== 64'h0) begin mismatched++; $display("FAIL mid_rst_rdata: got %h exp 0", ic_rdata); end
        reset = 1'b0; m_axi_rvalid = 1'b0;
        ic_araddr = 64'h7100; ic_arlen = 8'd0; ic_arvalid = 1'b1;
        tick();
        compared++; if (icache_busy !== 1'b1) begin mismatched++; $display("FAIL post_rst_grant: got %b exp 1", icache_busy); end
        tick();
        compared++; if ({m_axi_arvalid, m_axi_araddr} !== {1'b1, 64'h7100}) begin mismatched++; $display("FAIL post_rst_ar: got %b/%h exp 1/7100", m_axi_arvalid, m_axi_araddr); end
        tick();
        ic_arvalid = 1'b0;
        m_axi_rvalid = 1'b1; m_axi_rdata = 64'hE100; m_axi_rlast = 1'b1;
        #1;
        compared++; if ({ic_rvalid, ic_rdata} !== {1'b1, 64'hE100}) begin mismatched++; $display("FAIL post_rst_beat: got %b/%h exp 1/e100", ic_rvalid, ic_rdata); end
        tick();
        m_axi_rvalid = 1'b0; m_axi_rlast = 1'b0;
        compared++; if ({icache_busy, len_error} !== 2'b00) begin mismatched++; $display("FAIL post_rst_end: got busy/len_error %b exp 00", {icache_busy, len_error}); end
    endtask

    task automatic test_stray_rvalid();
        m_axi_rvalid = 1'b1; m_axi_rdata = 64'hBAD; m_axi_rlast = 1'b1;
        #1;
        compared++; if ({m_axi_rready, ic_rvalid, dc_rvalid} !== 3'b000) begin mismatched++; $display("FAIL stray_idle: got rready/ic/dc %b exp 000", {m_axi_rready, ic_rvalid, dc_rvalid}); end
        compared++; if ({ic_rdata, dc_rdata} !== 128'h0) begin mismatched++; $display("FAIL stray_idle_rdata: got %h/%h exp 0/0", ic_rdata, dc_rdata); end
        tick();
        m_axi_arready = 1'b0;
        dc_araddr = 64'h8000; dc_arlen = 8'd0; dc_arvalid = 1'b1;
        tick(); tick();
        compared++; if ({m_axi_rready, ic_rvalid, dc_rvalid} !== 3'b000) begin mismatched++; $display("FAIL stray_addr: got rready/ic/dc %b exp 000", {m_axi_rready, ic_rvalid, dc_rvalid}); end
        m_axi_rvalid = 1'b0; m_axi_rlast = 1'b0; m_axi_arready = 1'b1;
        tick();
        dc_arvalid = 1'b0;
        serve_beats(1, 64'hF000, 1'b1);
        compared++; if ({len_error, dcache_busy} !== 2'b00) begin mismatched++; $display("FAIL stray_end: got len_error/busy %b exp 00", {len_error, dcache_busy}); end
    endtask

    initial begin
        compared = 0; mismatched = 0;
        reset = 1'b1;
        ic_arvalid = 1'b0; ic_araddr = '0; ic_arlen = '0; ic_arsize = 3'd3; ic_arburst = 2'd1; ic_rready = 1'b1;
        dc_arvalid = 1'b0; dc_araddr = '0; dc_arlen = '0; dc_arsize = 3'd3; dc_arburst = 2'd1; dc_rready = 1'b1;
        m_axi_arready = 1'b1; m_axi_rvalid = 1'b0; m_axi_rdata = '0; m_axi_rlast = 1'b0;
        test_reset();
        test_tie();
        test_ic_only();
        test_backpressure();
        test_len_error();
        test_reset_mid_burst();
        test_stray_rvalid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
